// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline control types: FSM encoding, the per-bank control word and its canned values.
package pipe_pkg;

    localparam int REG_W = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_e;

    typedef struct packed {
        logic pcWrite;
        logic fdWrite;
        logic dxWrite;
        logic xmWrite;
        logic mwWrite;
        logic dxBubble;
        logic fdFlush;
    } ctrl_t;

    // All-zero word doubles as the NOP/bubble control loaded into a bank.
    localparam ctrl_t CTRL_FREEZE  = 7'b00000_00;
    localparam ctrl_t CTRL_ADVANCE = 7'b11111_00;
    localparam ctrl_t CTRL_LOADUSE = 7'b00111_10;
    localparam ctrl_t CTRL_SQUASH  = 7'b11111_11;

    function automatic ctrl_t runDecode(input logic memWait, input logic branchTaken,
                                        input logic loadUse);
        ctrl_t c;
        if (memWait)          c = CTRL_FREEZE;
        else if (branchTaken) c = CTRL_SQUASH;
        else if (loadUse)     c = CTRL_LOADUSE;
        else                  c = CTRL_ADVANCE;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: decode/execute/memory status in, pipeline bank controls out.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] DRs;
    logic [REG_W-1:0] DRt;
    logic             DUsesRs;
    logic             DUsesRt;
    logic [REG_W-1:0] XRd;
    logic             XMemRead;
    logic             XRegWrite;
    logic             XBranchTaken;
    logic             MMemAccess;
    logic             MemDone;
    logic             WHalt;
    logic             PCWrite;
    logic             FDWrite;
    logic             DXWrite;
    logic             XMWrite;
    logic             MWWrite;
    logic             DXBubble;
    logic             FDFlush;
    logic             MemReq;
    logic             Halted;
    logic [CNT_W-1:0] StallCnt;

    modport master (
        output DRs, DRt, DUsesRs, DUsesRt, XRd, XMemRead, XRegWrite, XBranchTaken,
               MMemAccess, MemDone, WHalt,
        input  PCWrite, FDWrite, DXWrite, XMWrite, MWWrite, DXBubble, FDFlush,
               MemReq, Halted, StallCnt
    );

    modport slave (
        input  DRs, DRt, DUsesRs, DUsesRt, XRd, XMemRead, XRegWrite, XBranchTaken,
               MMemAccess, MemDone, WHalt,
        output PCWrite, FDWrite, DXWrite, XMWrite, MWWrite, DXBubble, FDFlush,
               MemReq, Halted, StallCnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_stall_counter.sv
// Saturating stall-cycle counter with enable and asynchronous active-low clear.
module stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en_i && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Per-cycle advance/hold/bubble/flush decisions for the 5-stage pipeline, plus halt drain.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    state_e           state_q;
    state_e           state_d;
    logic             halted_q;
    ctrl_t            ctrl;
    logic             memReq;
    logic             loadUse;
    logic             memWait;
    logic             stallEn;
    logic [CNT_W-1:0] stallCnt;

    assign loadUse = bus.XMemRead & bus.XRegWrite &
                     ((bus.DUsesRs & (bus.XRd[REG_W-1:0] == bus.DRs[REG_W-1:0])) |
                      (bus.DUsesRt & (bus.XRd[REG_W-1:0] == bus.DRt[REG_W-1:0])));
    assign memWait = bus.MMemAccess & ~bus.MemDone;

    // Controls are combinational so a zero-wait access or a hazard costs no extra cycle.
    always_comb begin
        ctrl    = CTRL_FREEZE;
        memReq  = 1'b0;
        state_d = state_q;
        case (state_q)
            RUN: begin
                ctrl   = runDecode(memWait, bus.XBranchTaken, loadUse);
                memReq = bus.MMemAccess;
                if (memWait) state_d = MEM_WAIT;
                if (bus.WHalt) state_d = HALTED;
            end
            MEM_WAIT: begin
                memReq = bus.MMemAccess;
                if (bus.MemDone) begin
                    ctrl    = runDecode(1'b0, bus.XBranchTaken, loadUse);
                    state_d = RUN;
                end
                if (bus.WHalt) state_d = HALTED;
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
        if (!rst_n) begin
            ctrl   = CTRL_FREEZE;
            memReq = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALTED);
        end
    end

    assign stallEn = (state_q != HALTED) && !ctrl.pcWrite;

    stall_counter #(.CNT_W(CNT_W)) u_stall_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (stallEn),
        .count_o (stallCnt)
    );

    assign bus.PCWrite  = ctrl.pcWrite;
    assign bus.FDWrite  = ctrl.fdWrite;
    assign bus.DXWrite  = ctrl.dxWrite;
    assign bus.XMWrite  = ctrl.xmWrite;
    assign bus.MWWrite  = ctrl.mwWrite;
    assign bus.DXBubble = ctrl.dxBubble;
    assign bus.FDFlush  = ctrl.fdFlush;
    assign bus.MemReq   = memReq;
    assign bus.Halted   = halted_q;
    assign bus.StallCnt = stallCnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: a driver pushes reference-model expectations, a monitor pops and compares them.
module tb_pipe_hazard_ctrl;
    localparam int REG_W   = 3;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rn;
        logic [2:0] drs;
        logic [2:0] drt;
        logic       usesRs;
        logic       usesRt;
        logic [2:0] xrd;
        logic       memRead;
        logic       regWrite;
        logic       branch;
        logic       mAcc;
        logic       done;
        logic       halt;
    } stim_t;

    typedef struct {
        logic [6:0] ctrl;
        logic       memReq;
        logic       halted;
        int         cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    // Reference model: "waiting on memory", "halted", and a plain integer stall count.
    bit mWait = 1'b0;
    bit mHalt = 1'b0;
    int mCnt  = 0;

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   loadHaz;
        bit   memStall;
        @(negedge clk);
        rst_n            = s.rn;
        bus.DRs          = s.drs;
        bus.DRt          = s.drt;
        bus.DUsesRs      = s.usesRs;
        bus.DUsesRt      = s.usesRt;
        bus.XRd          = s.xrd;
        bus.XMemRead     = s.memRead;
        bus.XRegWrite    = s.regWrite;
        bus.XBranchTaken = s.branch;
        bus.MMemAccess   = s.mAcc;
        bus.MemDone      = s.done;
        bus.WHalt        = s.halt;
        #1;
        if (!s.rn) begin
            mWait = 1'b0;
            mHalt = 1'b0;
            mCnt  = 0;
            e.ctrl = 7'b0; e.memReq = 1'b0; e.halted = 1'b0; e.cnt = 0;
            expQ.push_back(e);
            return;
        end
        e.halted = mHalt;
        e.cnt    = mCnt;
        if (mHalt) begin
            e.ctrl   = 7'b0;
            e.memReq = 1'b0;
        end else begin
            loadHaz  = s.memRead && s.regWrite &&
                       ((s.usesRs && s.xrd == s.drs) || (s.usesRt && s.xrd == s.drt));
            memStall = mWait ? !s.done : (s.mAcc && !s.done);
            if (memStall)      e.ctrl = 7'b0000000;
            else if (s.branch) e.ctrl = 7'b1111111;
            else if (loadHaz)  e.ctrl = 7'b0011110;
            else               e.ctrl = 7'b1111100;
            e.memReq = s.mAcc;
            if (!e.ctrl[6] && mCnt < CNT_MAX) mCnt = mCnt + 1;
            mWait = memStall;
            if (s.halt) mHalt = 1'b1;
        end
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [6:0] actCtrl;
        actCtrl = {bus.PCWrite, bus.FDWrite, bus.DXWrite, bus.XMWrite, bus.MWWrite,
                   bus.DXBubble, bus.FDFlush};
        testsRun += 4;
        if (actCtrl !== e.ctrl) begin
            testsFailed++;
            $display("[TB] FAIL ctrl {PC,FD,DX,XM,MW,Bubble,Flush} at %0t: got %b expected %b",
                     $time, actCtrl, e.ctrl);
        end
        if (bus.MemReq !== e.memReq) begin
            testsFailed++;
            $display("[TB] FAIL MemReq at %0t: got %b expected %b", $time, bus.MemReq, e.memReq);
        end
        if (bus.Halted !== e.halted) begin
            testsFailed++;
            $display("[TB] FAIL Halted at %0t: got %b expected %b", $time, bus.Halted, e.halted);
        end
        if ($isunknown(bus.StallCnt) || int'(bus.StallCnt) != e.cnt) begin
            testsFailed++;
            $display("[TB] FAIL StallCnt at %0t: got %0d expected %0d", $time, bus.StallCnt, e.cnt);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    function automatic stim_t quiet();
        stim_t s;
        s = '0;
        s.rn = 1'b1;
        return s;
    endfunction

    function automatic stim_t randomStim(input bit haltOk, input bit resetOk);
        stim_t s;
        s.rn       = !(resetOk && $urandom_range(0, 49) == 0);
        s.drs      = 3'($urandom_range(0, 3));
        s.drt      = 3'($urandom_range(0, 3));
        s.usesRs   = 1'($urandom_range(0, 1));
        s.usesRt   = 1'($urandom_range(0, 1));
        s.xrd      = 3'($urandom_range(0, 3));
        s.memRead  = ($urandom_range(0, 2) == 0);
        s.regWrite = ($urandom_range(0, 3) != 0);
        s.branch   = ($urandom_range(0, 6) == 0);
        s.mAcc     = ($urandom_range(0, 3) == 0);
        s.done     = 1'($urandom_range(0, 1));
        s.halt     = haltOk && ($urandom_range(0, 99) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        stim_t r;
        r = '0;
        bus.DRs = '0; bus.DRt = '0; bus.DUsesRs = 0; bus.DUsesRt = 0; bus.XRd = '0;
        bus.XMemRead = 0; bus.XRegWrite = 0; bus.XBranchTaken = 0;
        bus.MMemAccess = 0; bus.MemDone = 0; bus.WHalt = 0;

        // Reset state, with a pending memory access that must not raise MemReq.
        s = r; s.mAcc = 1'b1; applyStimulus(s);
        applyStimulus(r);
        applyStimulus(quiet());

        // Load to r3 consumed via Rs: one bubble, then free flow.
        s = quiet(); s.drs = 3'd3; s.usesRs = 1; s.xrd = 3'd3; s.memRead = 1; s.regWrite = 1;
        applyStimulus(s);
        s.memRead = 0; applyStimulus(s);
        // Load-use via Rt, with Rs mismatching.
        s = quiet(); s.drs = 3'd1; s.drt = 3'd5; s.usesRs = 1; s.usesRt = 1; s.xrd = 3'd5;
        s.memRead = 1; s.regWrite = 1;
        applyStimulus(s);
        // Load-use together with a taken branch: the branch wins.
        s.branch = 1; applyStimulus(s);
        applyStimulus(quiet());

        // Three-wait access, then a zero-wait access.
        s = quiet(); s.mAcc = 1;
        for (int i = 0; i < 3; i++) applyStimulus(s);
        s.done = 1; applyStimulus(s);
        applyStimulus(quiet());
        applyStimulus(s);
        applyStimulus(quiet());

        // Halt together with MemDone in MEM_WAIT, then ignored hazards.
        s = quiet(); s.mAcc = 1; applyStimulus(s);
        s.done = 1; s.halt = 1; s.branch = 1; applyStimulus(s);
        for (int i = 0; i < 4; i++) applyStimulus(randomStim(1'b1, 1'b0));

        // Reset asserted in the middle of a memory wait.
        applyStimulus(r);
        s = quiet(); s.mAcc = 1;
        applyStimulus(s); applyStimulus(s); applyStimulus(s);
        s.rn = 0; applyStimulus(s);
        applyStimulus(quiet());

        // Randomised segments, each started from reset.
        for (int seg = 0; seg < 6; seg++) begin
            applyStimulus(r);
            for (int i = 0; i < 200; i++) applyStimulus(randomStim(1'b1, 1'b1));
        end

        // Long memory wait drives the stall counter into saturation.
        applyStimulus(r);
        s = quiet(); s.mAcc = 1;
        for (int i = 0; i < CNT_MAX + 10; i++) applyStimulus(s);
        s.done = 1; applyStimulus(s);
        s = quiet(); s.drs = 3'd2; s.usesRs = 1; s.xrd = 3'd2; s.memRead = 1; s.regWrite = 1;
        applyStimulus(s);
        applyStimulus(quiet());
        applyStimulus(quiet());

        @(negedge clk);
        #3;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
